inst_memory_ctrl: RTL and testbench
===================================

# inst_memory_ctrl

Parametrised instruction memory with a load port, a fetch handshake and a small control FSM. It sits between the program loader and the CPU fetch stage: the loader fills the array word by word, then the CPU issues fetch requests and receives one word per accepted request with fixed one-cycle latency. The CPU can stall and hold the returned word. This block generalises the fixed 256×16 synchronous instruction memory to configurable width and depth, and adds loading, handshaking, stall and fetch counting.

## Interface
Parameters:
- DATA_W, 16, instruction word width in bits
- ADDR_W, 8, address width; depth = 2**ADDR_W words
- CNT_W, 16, width of the fetch counter

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- ld_en  in  1  load-mode request, level
- ld_we  in  1  load write strobe; honoured only in LOAD
- ld_addr  in  ADDR_W  load write address
- ld_data  in  DATA_W  load write data
- start  in  1  one-cycle pulse: IDLE→RUN
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_stall  in  1  CPU stall; holds the current output word
- i_ready  out  1  fetch request is accepted this cycle
- i_valid  out  1  i_dataout holds a fetched word
- i_dataout  out  DATA_W  fetched instruction
- busy  out  1  high in LOAD
- fetch_cnt  out  CNT_W  number of accepted fetches since reset, wrapping

## Operation
- FSM states: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE:
  - ld_en=1 → LOAD.
  - Otherwise start=1 → RUN.
  - ld_en has priority over start.
- LOAD:
  - busy=1, i_ready=0.
  - ld_we=1 writes ld_data to mem[ld_addr] at the clock edge.
  - ld_en=0 → IDLE.
- RUN:
  - i_ready = !(i_valid && i_stall).
  - ld_en=1 → LOAD at the next edge. A fetch accepted in that same cycle still completes: i_valid rises and its data is correct.
  - start is ignored.
- Accepted fetch (i_req && i_ready in RUN):
  - At the edge, i_dataout ← mem[i_addr], i_valid ← 1, fetch_cnt ← fetch_cnt+1 modulo 2**CNT_W.
- No request and no stall: i_valid ← 0 at the edge. i_dataout keeps its last value.
- Stall (i_valid=1 and i_stall=1):
  - i_dataout and i_valid are held.
  - No request is accepted and fetch_cnt is unchanged.
- i_stall while i_valid=0 has no effect; requests are still accepted.
- ld_we outside LOAD is ignored and the memory is unchanged.
- The address range is fully decoded (depth = 2**ADDR_W), so no address is ever out of range.
- Memory contents are not reset. A fetch from an unwritten location returns an undefined value.

## Timing
- Reset values: state=IDLE, i_valid=0, i_dataout=0, busy=0, i_ready=0, fetch_cnt=0.
- Fetch latency is 1 cycle: request accepted at edge k → data valid after edge k; throughput is 1 word/cycle.
- busy and i_ready are decoded combinationally from the state register; i_ready also depends on i_valid and i_stall.
- A load write at edge k is visible to a fetch accepted at edge k+2 or later. The path is LOAD→IDLE→RUN, which takes at least 2 edges.
- reset_n asserted mid-fetch or mid-load:
  - Outputs clear immediately, without waiting for a clock edge.
  - Memory contents written before the reset are retained.

## Configuration
- INST_MEM_PARITY_EN:
  - Defined:
    - Each stored word carries one extra even-parity bit, computed on load.
    - Output par_err (1 bit) is registered alongside i_dataout. It is high when the fetched word's parity mismatches. It resets to 0 and is held during stall.
  - Undefined: no parity storage and no par_err port.

## Test plan
- Reset, then load mem[0]=16'h1234 and mem[255]=16'hBEEF, drop ld_en, pulse start, fetch address 0 then 255 back-to-back → i_dataout 1234 then BEEF on consecutive cycles with i_valid=1; fetch_cnt=2.
- Fetch address 0 with i_stall=1 for 3 cycles while i_req stays high with address 255 → i_dataout holds 1234, i_ready=0, and fetch_cnt does not change. Releasing the stall accepts address 255 on the next edge.
- In RUN, assert ld_en in the same cycle as a fetch of address 255 → BEEF is returned, state becomes LOAD, and busy=1. ld_we to address 0 in RUN is ignored.
- With CNT_W=4, perform 17 fetches → fetch_cnt=1 (wrap-around).
- Assert reset_n low mid-burst → i_valid, i_dataout and fetch_cnt become 0 asynchronously and state is IDLE. After restart, fetching address 0 still returns 1234.
- With INST_MEM_PARITY_EN defined, force-corrupt one stored bit of mem[0] and fetch it → par_err=1 together with i_valid. An uncorrupted word gives par_err=0.

Source files
------------

// File: rtl/inst_memory_ctrl.sv
// Instruction memory with a loader port, one-cycle fetch handshake and IDLE/LOAD/RUN control.
// Define INST_MEM_PARITY_EN to store an even-parity bit per word and expose par_err.
module inst_memory_ctrl #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ld_en,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              start,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_stall,
   output logic              i_ready,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_dataout,
   output logic              busy,
`ifdef INST_MEM_PARITY_EN
   output logic              par_err,
`endif
   output logic [CNT_W-1:0]  fetch_cnt
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef INST_MEM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

   state_e state_q, state_d;

   logic [MEM_W-1:0]  mem [DEPTH];
   logic [MEM_W-1:0]  wr_word;
   logic [MEM_W-1:0]  rd_word;
   logic              accept;

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

`ifdef INST_MEM_PARITY_EN
   logic              par_q, par_d;
   assign wr_word = {^ld_data, ld_data};
`else
   assign wr_word = ld_data;
`endif

   assign rd_word = mem[i_addr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (ld_en) begin
               state_d = StLoad;
            end else if (start) begin
               state_d = StRun;
            end
         end
         StLoad: begin
            if (!ld_en) begin
               state_d = StIdle;
            end
         end
         StRun: begin
            if (ld_en) begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign busy    = (state_q == StLoad);
   assign i_ready = (state_q == StRun) && !(valid_q && i_stall);
   assign accept  = i_req && i_ready;

   // Contents survive reset on purpose so a program need not be reloaded.
   always_ff @(posedge clock) begin
      if (busy && ld_we) begin
         mem[ld_addr] <= wr_word;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
`ifdef INST_MEM_PARITY_EN
      par_d   = par_q;
`endif
      if (accept) begin
         valid_d = 1'b1;
         data_d  = rd_word[DATA_W-1:0];
         cnt_d   = cnt_q + CNT_W'(1);
`ifdef INST_MEM_PARITY_EN
         par_d   = ^rd_word;
`endif
      end else if (!(valid_q && i_stall)) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
`ifdef INST_MEM_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
`ifdef INST_MEM_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign i_valid   = valid_q;
   assign i_dataout = data_q;
   assign fetch_cnt = cnt_q;
`ifdef INST_MEM_PARITY_EN
   assign par_err   = par_q;
`endif

endmodule

// File: tb/tb_inst_memory_ctrl.sv
// Directed bench for inst_memory_ctrl (CNT_W=4 so the fetch counter wrap is reachable).
// The parity checks are compiled in only when INST_MEM_PARITY_EN is defined.
module tb_inst_memory_ctrl;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CNT_W  = 4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              ld_en, ld_we, start, i_req, i_stall;
   logic [ADDR_W-1:0] ld_addr, i_addr;
   logic [DATA_W-1:0] ld_data;
   logic              i_ready, i_valid, busy;
   logic [DATA_W-1:0] i_dataout;
   logic [CNT_W-1:0]  fetch_cnt;
`ifdef INST_MEM_PARITY_EN
   logic              par_err;
`endif

   int total = 0;
   int bad   = 0;

   inst_memory_ctrl #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .ld_en    (ld_en),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .start    (start),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_stall  (i_stall),
      .i_ready  (i_ready),
      .i_valid  (i_valid),
      .i_dataout(i_dataout),
      .busy     (busy),
`ifdef INST_MEM_PARITY_EN
      .par_err  (par_err),
`endif
      .fetch_cnt(fetch_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      ld_en   = 1'b0;
      ld_we   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      start   = 1'b0;
      i_req   = 1'b0;
      i_addr  = '0;
      i_stall = 1'b0;
      #12;
      check("rst_valid", 32'(i_valid), 32'd0);
      check("rst_data", 32'(i_dataout), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(i_ready), 32'd0);
      check("rst_cnt", 32'(fetch_cnt), 32'd0);
      reset_n = 1'b1;

      // Load mem[0] and mem[255].
      ld_en = 1'b1;
      step();
      check("load_busy", 32'(busy), 32'd1);
      check("load_ready", 32'(i_ready), 32'd0);
      ld_we = 1'b1; ld_addr = 8'd0; ld_data = 16'h1234;
      step();
      ld_addr = 8'd255; ld_data = 16'hBEEF;
      step();
      ld_we = 1'b0; ld_en = 1'b0;
      step();
      check("idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("run_ready", 32'(i_ready), 32'd1);

      // Back-to-back fetches.
      i_req = 1'b1; i_addr = 8'd0;
      step();
      check("f0_data", 32'(i_dataout), 32'h1234);
      check("f0_valid", 32'(i_valid), 32'd1);
      i_addr = 8'd255;
      step();
      check("f1_data", 32'(i_dataout), 32'hBEEF);
      check("f1_valid", 32'(i_valid), 32'd1);
      check("f1_cnt", 32'(fetch_cnt), 32'd2);
      i_req = 1'b0;
      step();
      check("idle_valid", 32'(i_valid), 32'd0);
      check("idle_hold", 32'(i_dataout), 32'hBEEF);

      // Stall holds the word for three cycles, then releases.
      i_req = 1'b1; i_addr = 8'd0;
      step();
      check("s0_data", 32'(i_dataout), 32'h1234);
      check("s0_cnt", 32'(fetch_cnt), 32'd3);
      i_stall = 1'b1; i_addr = 8'd255;
      #1;
      check("stall_ready", 32'(i_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_data", 32'(i_dataout), 32'h1234);
         check("stall_valid", 32'(i_valid), 32'd1);
         check("stall_cnt", 32'(fetch_cnt), 32'd3);
      end
      i_stall = 1'b0;
      #1;
      check("unstall_ready", 32'(i_ready), 32'd1);
      step();
      check("unstall_data", 32'(i_dataout), 32'hBEEF);
      check("unstall_cnt", 32'(fetch_cnt), 32'd4);

      // ld_we in RUN must not write.
      i_req = 1'b0; ld_we = 1'b1; ld_addr = 8'd0; ld_data = 16'h0000;
      step();
      ld_we = 1'b0; i_req = 1'b1; i_addr = 8'd0;
      step();
      check("run_we_ign", 32'(i_dataout), 32'h1234);
      check("run_we_cnt", 32'(fetch_cnt), 32'd5);

      // ld_en with a fetch in the same cycle: fetch completes, then LOAD.
      ld_en = 1'b1; i_addr = 8'd255;
      step();
      check("ldf_data", 32'(i_dataout), 32'hBEEF);
      check("ldf_valid", 32'(i_valid), 32'd1);
      check("ldf_busy", 32'(busy), 32'd1);
      check("ldf_ready", 32'(i_ready), 32'd0);
      check("ldf_cnt", 32'(fetch_cnt), 32'd6);
      ld_en = 1'b0; i_req = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;

      // Asynchronous reset mid-burst.
      i_req = 1'b1; i_addr = 8'd0;
      step();
      step();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(i_valid), 32'd0);
      check("arst_data", 32'(i_dataout), 32'd0);
      check("arst_cnt", 32'(fetch_cnt), 32'd0);
      check("arst_ready", 32'(i_ready), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      i_req = 1'b0;
      #3;
      reset_n = 1'b1;
      step();
      check("post_idle_ready", 32'(i_ready), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;

      // Stall with no valid word does not block acceptance.
      i_stall = 1'b1; i_req = 1'b1; i_addr = 8'd0;
      #1;
      check("nv_stall_ready", 32'(i_ready), 32'd1);
      step();
      i_stall = 1'b0;
      check("retain_data", 32'(i_dataout), 32'h1234);
      check("retain_cnt", 32'(fetch_cnt), 32'd1);

      // Sixteen more fetches: 17 total wraps the 4-bit counter to 1.
      for (int i = 0; i < 16; i++) begin
         i_addr = (i % 2 == 0) ? 8'd255 : 8'd0;
         step();
      end
      check("wrap_cnt", 32'(fetch_cnt), 32'd1);
      check("wrap_data", 32'(i_dataout), 32'h1234);

`ifdef INST_MEM_PARITY_EN
      i_addr = 8'd255;
      step();
      check("par_clean", 32'(par_err), 32'd0);
      dut.mem[0] = dut.mem[0] ^ 17'h00001;
      i_addr = 8'd0;
      step();
      check("par_bad", 32'(par_err), 32'd1);
      check("par_bad_valid", 32'(i_valid), 32'd1);
`endif
      i_req = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
